// File: rtl/symm_iter_ctrl.sv
// rtl/symm_iter_ctrl.sv - sequencer for the FastICA symmetric-decorrelation loop
//
// Drives the enable/select pair of the 4x4 weight-matrix selector.
// It loads the initial W once, then repeatedly launches the decorrelation datapath
// and captures its fed-back result until one of these occurs: convergence, the
// iteration limit, a watchdog timeout, or an abort.
//
// Optional feature: define SYMM_CTRL_WDOG_EN to build the WAIT-state watchdog.
// Without it, WAIT waits indefinitely and timeout_err is constant 0.
//
// Ports:
//   clk_ctl      in   clock, all logic on posedge
//   rst_ctl      in   synchronous active-high reset
//   start        in   run request, sampled only in IDLE
//   abort        in   cancel run from any non-IDLE state
//   dp_done      in   datapath result valid pulse, sampled only in WAIT
//   converged    in   convergence flag, qualified by dp_done
//   en_sel       out  selector capture enable (LOAD/UPDATE only)
//   select       out  selector source: 0 = initial W, 1 = datapath feedback
//   dp_start     out  one-cycle datapath launch pulse
//   busy         out  high in every state except IDLE
//   done         out  one-cycle run-complete pulse
//   iter_cnt     out  feedback captures in current/last run
//   timeout_err  out  sticky watchdog flag
module symm_iter_ctrl #(
    parameter int MAX_ITER = 16,
    parameter int ITER_W   = 5,
    parameter int WDOG_CYC = 255
) (
    input  logic              clk_ctl,
    input  logic              rst_ctl,
    input  logic              start,
    input  logic              abort,
    input  logic              dp_done,
    input  logic              converged,
    output logic              en_sel,
    output logic              select,
    output logic              dp_start,
    output logic              busy,
    output logic              done,
    output logic [ITER_W-1:0] iter_cnt,
    output logic              timeout_err
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_KICK   = 3'd2;
    localparam logic [2:0] S_WAIT   = 3'd3;
    localparam logic [2:0] S_UPDATE = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    localparam logic [ITER_W-1:0] ITER_LIMIT = ITER_W'(MAX_ITER);

    logic [2:0]        state_q, state_d;
    logic [ITER_W-1:0] iter_cnt_q, iter_cnt_d;
    logic              conv_q, conv_d;
    logic              en_sel_q, en_sel_d;
    logic              select_q, select_d;
    logic              dp_start_q, dp_start_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              wdog_expire;
    logic              tmo_set;
    logic              tmo_clr;

`ifdef SYMM_CTRL_WDOG_EN
    // One extra count of headroom: the counter steps once more on the expiry cycle.
    localparam int WDOG_W = $clog2(WDOG_CYC + 1);
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYC - 1);

    logic [WDOG_W-1:0] wdog_q, wdog_d;
    logic              timeout_err_q, timeout_err_d;

    assign wdog_expire = (state_q == S_WAIT) && (wdog_q == WDOG_LAST);

    always_comb begin
        wdog_d = wdog_q;
        if (state_q == S_KICK) begin
            wdog_d = '0;
        end else if (state_q == S_WAIT) begin
            wdog_d = wdog_q + 1'b1;
        end
    end

    always_comb begin
        timeout_err_d = timeout_err_q;
        if (tmo_clr) begin
            timeout_err_d = 1'b0;
        end else if (tmo_set) begin
            timeout_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_ctl) begin
        if (rst_ctl) begin
            wdog_q        <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            wdog_q        <= wdog_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign timeout_err = timeout_err_q;
`else
    assign wdog_expire = 1'b0;
    // WDOG_CYC is always >= 1, so this folds to constant 0; referencing it keeps
    // the parameter list meaningful in both builds.
    assign timeout_err = (WDOG_CYC < 1);
`endif

    always_comb begin
        state_d    = state_q;
        iter_cnt_d = iter_cnt_q;
        conv_d     = conv_q;
        tmo_set    = 1'b0;
        tmo_clr    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_LOAD;
                    iter_cnt_d = '0;
                    tmo_clr    = 1'b1;
                end
            end
            S_LOAD:  state_d = S_KICK;
            S_KICK:  state_d = S_WAIT;
            S_WAIT: begin
                // dp_done beats a simultaneous watchdog expiry.
                if (dp_done) begin
                    state_d    = S_UPDATE;
                    conv_d     = converged;
                    // Counted on entry, so UPDATE already shows the new value.
                    // WAIT is only reached with iter_cnt < MAX_ITER.
                    iter_cnt_d = iter_cnt_q + 1'b1;
                end else if (wdog_expire) begin
                    state_d = S_DONE;
                    tmo_set = 1'b1;
                end
            end
            S_UPDATE: begin
                if (conv_q || (iter_cnt_q == ITER_LIMIT)) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_KICK;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Abort overrides everything decided above for this cycle.
        if (abort && (state_q != S_IDLE)) begin
            state_d    = S_IDLE;
            iter_cnt_d = iter_cnt_q;
            conv_d     = conv_q;
            tmo_set    = 1'b0;
        end
    end

    // Outputs are registered from the next state, so they line up with state_q.
    always_comb begin
        en_sel_d   = (state_d == S_LOAD) || (state_d == S_UPDATE);
        select_d   = (state_d == S_UPDATE);
        dp_start_d = (state_d == S_KICK);
        busy_d     = (state_d != S_IDLE);
        done_d     = (state_d == S_DONE);
    end

    always_ff @(posedge clk_ctl) begin
        if (rst_ctl) begin
            state_q    <= S_IDLE;
            iter_cnt_q <= '0;
            conv_q     <= 1'b0;
            en_sel_q   <= 1'b0;
            select_q   <= 1'b0;
            dp_start_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            iter_cnt_q <= iter_cnt_d;
            conv_q     <= conv_d;
            en_sel_q   <= en_sel_d;
            select_q   <= select_d;
            dp_start_q <= dp_start_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign en_sel   = en_sel_q;
    assign select   = select_q;
    assign dp_start = dp_start_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign iter_cnt = iter_cnt_q;

endmodule

// File: tb/tb_symm_iter_ctrl.sv
// tb/tb_symm_iter_ctrl.sv - scoreboard bench for symm_iter_ctrl
module tb_symm_iter_ctrl;

    logic       clk_ctl = 1'b0;
    logic       rst_ctl = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       dp_done = 1'b0;
    logic       converged = 1'b0;
    logic       en_sel, select, dp_start, busy, done, timeout_err;
    logic [4:0] iter_cnt;

    int n_vec = 0;
    int n_err = 0;
    int n_kick = 0;

    logic       sel_q[$];   // expected select value per en_sel capture
    logic [5:0] done_q[$];  // expected {timeout_err, iter_cnt} per done pulse

    symm_iter_ctrl #(.MAX_ITER(16), .ITER_W(5), .WDOG_CYC(8)) dut (
        .clk_ctl(clk_ctl), .rst_ctl(rst_ctl), .start(start), .abort(abort),
        .dp_done(dp_done), .converged(converged), .en_sel(en_sel), .select(select),
        .dp_start(dp_start), .busy(busy), .done(done), .iter_cnt(iter_cnt),
        .timeout_err(timeout_err)
    );

    always #5 clk_ctl = ~clk_ctl;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a capture or done.
    always @(negedge clk_ctl) begin
        if (dp_start) n_kick++;
        if (en_sel) begin
            if (sel_q.size() == 0) chk("unexpected_en_sel", 1, 0);
            else chk("capture_select", {31'd0, select}, {31'd0, sel_q.pop_front()});
        end
        if (done) begin
            if (done_q.size() == 0) chk("unexpected_done", 1, 0);
            else chk("done_tmo_iter", {26'd0, timeout_err, iter_cnt}, {26'd0, done_q.pop_front()});
        end
    end

    task automatic start_run();
        @(posedge clk_ctl); #1 start = 1'b1;
        @(posedge clk_ctl); #1 start = 1'b0;
    endtask

    task automatic wait_kick();
        int i;
        for (i = 0; i < 50; i++) begin
            @(negedge clk_ctl);
            if (dp_start) break;
        end
        if (i == 50) chk("dp_start_timeout", 0, 1);
    endtask

    // dp_done is high in the second cycle after KICK; returns in the UPDATE cycle.
    task automatic pulse_done(input logic conv);
        repeat (2) @(posedge clk_ctl);
        #1 dp_done = 1'b1; converged = conv;
        @(posedge clk_ctl); #1 dp_done = 1'b0; converged = 1'b0;
    endtask

    task automatic wait_idle();
        int i;
        for (i = 0; i < 50; i++) begin
            @(negedge clk_ctl);
            if (!busy) break;
        end
        if (i == 50) chk("idle_timeout", 0, 1);
    endtask

    initial begin
        int k0;
        // Reset
        repeat (3) @(posedge clk_ctl);
        #1 rst_ctl = 1'b0;
        @(negedge clk_ctl);
        chk("rst_outputs", {26'd0, en_sel, select, dp_start, busy, done, timeout_err}, 0);
        chk("rst_iter", iter_cnt, 0);

        // 1: full run to MAX_ITER
        sel_q.push_back(1'b0);
        for (int i = 0; i < 16; i++) sel_q.push_back(1'b1);
        done_q.push_back({1'b0, 5'd16});
        k0 = n_kick;
        start_run();
        for (int i = 0; i < 16; i++) begin
            wait_kick();
            pulse_done(1'b0);
        end
        wait_idle();
        chk("maxiter_iter", iter_cnt, 16);
        chk("maxiter_kicks", n_kick - k0, 16);
        repeat (3) @(negedge clk_ctl);
        chk("maxiter_hold", iter_cnt, 16);

        // 2: converged on third result
        sel_q.push_back(1'b0);
        for (int i = 0; i < 3; i++) sel_q.push_back(1'b1);
        done_q.push_back({1'b0, 5'd3});
        k0 = n_kick;
        start_run();
        for (int i = 0; i < 3; i++) begin
            wait_kick();
            pulse_done(i == 2);
        end
        @(negedge clk_ctl);
        chk("conv_update", {29'd0, en_sel, select, done}, 3'b110);
        chk("conv_iter", iter_cnt, 3);
        @(negedge clk_ctl);
        chk("conv_done", {30'd0, done, busy}, 2'b11);
        @(negedge clk_ctl);
        chk("conv_idle", {30'd0, done, busy}, 2'b00);
        repeat (4) @(negedge clk_ctl);
        chk("conv_kicks", n_kick - k0, 3);

        // 3: abort in WAIT of iteration 2
        sel_q.push_back(1'b0);
        sel_q.push_back(1'b1);
        start_run();
        wait_kick();
        pulse_done(1'b0);
        wait_kick();
        @(posedge clk_ctl); #1 abort = 1'b1; dp_done = 1'b1;
        @(posedge clk_ctl); #1 abort = 1'b0; dp_done = 1'b0;
        @(negedge clk_ctl);
        chk("abort_state", {29'd0, busy, en_sel, done}, 0);
        chk("abort_iter", iter_cnt, 1);
        repeat (4) @(negedge clk_ctl);
        chk("abort_stays_idle", busy, 0);

        // 4: datapath never answers
`ifdef SYMM_CTRL_WDOG_EN
        sel_q.push_back(1'b0);
        done_q.push_back({1'b1, 5'd0});
        start_run();
        wait_kick();
        repeat (8) @(negedge clk_ctl);
        chk("wdog_wait8", {30'd0, busy, done}, 2'b10);
        @(negedge clk_ctl);
        chk("wdog_done", {30'd0, done, timeout_err}, 2'b11);
        @(negedge clk_ctl);
        chk("wdog_sticky", {30'd0, busy, timeout_err}, 2'b01);
        sel_q.push_back(1'b0);
        start_run();
        @(negedge clk_ctl);
        chk("wdog_cleared", {30'd0, busy, timeout_err}, 2'b10);
`else
        sel_q.push_back(1'b0);
        start_run();
        wait_kick();
        repeat (20) @(negedge clk_ctl);
        chk("nowdog_waiting", {30'd0, busy, timeout_err}, 2'b10);
`endif
        @(posedge clk_ctl); #1 abort = 1'b1;
        @(posedge clk_ctl); #1 abort = 1'b0;
        @(negedge clk_ctl);
        chk("wdog_abort_idle", busy, 0);

        // 5: spurious start/dp_done
        @(posedge clk_ctl); #1 dp_done = 1'b1; converged = 1'b1;
        @(posedge clk_ctl); #1 dp_done = 1'b0; converged = 1'b0;
        @(negedge clk_ctl);
        chk("spur_idle_dpdone", busy, 0);
        sel_q.push_back(1'b0);
        sel_q.push_back(1'b1);
        done_q.push_back({1'b0, 5'd1});
        k0 = n_kick;
        @(posedge clk_ctl); #1 start = 1'b1;
        @(posedge clk_ctl); #1 start = 1'b1;                       // LOAD
        @(posedge clk_ctl); #1 dp_done = 1'b1; converged = 1'b1;   // KICK
        @(posedge clk_ctl); #1 dp_done = 1'b0; converged = 1'b0; start = 1'b0;
        repeat (3) @(negedge clk_ctl);
        chk("spur_still_wait", {27'd0, busy, iter_cnt}, {27'd0, 1'b1, 5'd0});
        @(posedge clk_ctl); #1 dp_done = 1'b1; converged = 1'b1;
        @(posedge clk_ctl); #1 dp_done = 1'b0; converged = 1'b0;
        wait_idle();
        chk("spur_iter", iter_cnt, 1);
        chk("spur_kicks", n_kick - k0, 1);

        // 6: reset during UPDATE
        sel_q.push_back(1'b0);
        sel_q.push_back(1'b1);
        start_run();
        wait_kick();
        pulse_done(1'b0);
        rst_ctl = 1'b1;
        @(posedge clk_ctl); #1 rst_ctl = 1'b0;
        @(negedge clk_ctl);
        chk("rst_mid_outputs", {26'd0, en_sel, select, dp_start, busy, done, timeout_err}, 0);
        chk("rst_mid_iter", iter_cnt, 0);
        repeat (4) @(negedge clk_ctl);

        chk("sel_queue_empty", sel_q.size(), 0);
        chk("done_queue_empty", done_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/symm_iter_ctrl.md
# symm_iter_ctrl

Sequencer for the symmetric-decorrelation loop of the FastICA processor. It drives the enable/select pair of the 4x4 weight-matrix selector register: it loads the initial W once, then repeatedly launches the decorrelation datapath and captures its fed-back result. Iteration stops on convergence, on an iteration limit, on a watchdog timeout or on abort. The block sits between the top-level processor control and the selector/decorrelation datapath.

## Interface
- MAX_ITER, 16, maximum number of feedback captures per run (≥1)
- ITER_W, 5, width of iter_cnt; must hold the value MAX_ITER
- WDOG_CYC, 255, WAIT-state cycle limit before timeout (≥1)

- clk_ctl  in  1  clock; all logic on posedge
- rst_ctl  in  1  synchronous, active-high reset
- start  in  1  run request; sampled only in IDLE
- abort  in  1  cancel run; any non-IDLE state
- dp_done  in  1  one-cycle pulse: datapath result valid; sampled only in WAIT
- converged  in  1  convergence flag; qualified by dp_done
- en_sel  out  1  selector capture enable
- select  out  1  selector source: 0 = initial W, 1 = datapath feedback
- dp_start  out  1  one-cycle launch pulse to datapath
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle run-complete pulse
- iter_cnt  out  ITER_W  feedback captures in current/last run
- timeout_err  out  1  sticky watchdog flag

## Operation
- All outputs are registered Moore outputs of the state and counters.
- Reset: state IDLE; en_sel, select, dp_start, busy, done, timeout_err = 0; iter_cnt = 0; watchdog = 0.
- FSM states and transitions:
  - IDLE: start=1 goes to LOAD; also clears iter_cnt and timeout_err.
  - LOAD: en_sel=1, select=0 for one cycle; goes to KICK.
  - KICK: dp_start=1 for one cycle; clears the watchdog; goes to WAIT.
  - WAIT: the watchdog increments each cycle.
    - dp_done=1 goes to UPDATE and latches converged.
    - With the watchdog compiled in and watchdog == WDOG_CYC-1 without dp_done: goes to DONE and sets timeout_err.
  - UPDATE: en_sel=1, select=1 for one cycle; iter_cnt+1.
    - Goes to DONE if latched converged=1 or the new iter_cnt == MAX_ITER.
    - Otherwise goes to KICK.
  - DONE: done=1 for one cycle; goes to IDLE.
- select = 1 only in UPDATE; 0 in all other states.
- en_sel is never high outside LOAD/UPDATE, so the selector holds W between captures.
- abort=1 in any non-IDLE state goes to IDLE next cycle: no done, no en_sel, iter_cnt holds.
- abort has priority over dp_done and over the watchdog expiry in the same cycle.
- start while busy is ignored. dp_done outside WAIT is ignored.
- dp_done and watchdog expiry in the same cycle: dp_done wins, and timeout_err is not set.
- iter_cnt holds its final value after DONE until the next accepted start; it never exceeds MAX_ITER.
- rst_ctl mid-run returns to the reset values next edge, with no done pulse.

## Timing
- start sampled at edge 0 → LOAD (en_sel, select=0) in cycle 1 → dp_start in cycle 2 → WAIT from cycle 3.
- dp_done sampled at edge k → UPDATE (en_sel, select=1) in cycle k+1 → cycle k+2 is KICK (dp_start) or DONE (done) → cycle k+3 IDLE (busy=0) after DONE.
- Minimum per-iteration loop: 3 cycles (KICK, WAIT with immediate dp_done, UPDATE).
- The earliest new start is accepted in the first IDLE cycle after DONE.

## Configuration
- SYMM_CTRL_WDOG_EN defined:
  - Watchdog counter and timeout path present.
  - timeout_err is set on expiry and cleared only by reset or an accepted start.
- SYMM_CTRL_WDOG_EN undefined:
  - No watchdog logic; WAIT waits indefinitely for dp_done or abort.
  - timeout_err is constant 0.

## Test plan
- Reset, then start; dp_done at 2 cycles after each dp_start with converged=0; MAX_ITER=16 → exactly 1 LOAD capture (select=0) and 16 UPDATE captures (select=1); iter_cnt=16; single done pulse.
- converged=1 on the 3rd dp_done → iter_cnt=3; done 2 cycles after that dp_done; no 4th dp_start.
- abort asserted in WAIT during iteration 2 → IDLE next cycle, busy=0, no done, no en_sel; iter_cnt=1.
- Watchdog build, WDOG_CYC=8, dp_done never arrives → timeout_err=1 and done pulse after 8 WAIT cycles; next start clears timeout_err. Non-watchdog build → busy stays high and timeout_err stays 0.
- start pulses while busy and spurious dp_done in IDLE/KICK → no state change, no extra captures.
- rst_ctl asserted in UPDATE → next cycle all outputs at reset values, iter_cnt=0.
